// File: rtl/config_arbiter.sv
// Two-requester round-robin front end for the single Config write port.
// One write in flight at a time: grant, strobe c_valid until ack or timeout, then report done.
module config_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [1:0] a_addr,
  input  logic [7:0] a_data,
  output logic       a_ready,
  output logic       a_done,
  input  logic       b_valid,
  input  logic [1:0] b_addr,
  input  logic [7:0] b_data,
  output logic       b_ready,
  output logic       b_done,
  output logic       done_err,
  output logic       busy,
  output logic       c_valid,
  output logic [1:0] c_addr,
  output logic [7:0] c_data,
  input  logic       c_UART_ready,
  input  logic       c_VGA_ready
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]       r_state;
  logic             r_owner;   // 0 = A, 1 = B
  logic             r_last;    // last grant, 0 = A, 1 = B
  logic [CNT_W-1:0] r_cnt;
  logic             r_c_valid;
  logic [1:0]       r_c_addr;
  logic [7:0]       r_c_data;
  logic [1:0]       r_ready;   // [1] = B, [0] = A
  logic [1:0]       r_done;
  logic             r_done_err;

  logic             w_req;
  logic             w_grant_b;
  logic [1:0]       w_addr;
  logic [7:0]       w_data;
  logic             w_addr_ok;
  logic             w_ack;
  logic             w_tmo;

  // B wins only when A is idle or A was served last; A wins the first tie after reset.
  assign w_req     = a_valid | b_valid;
  assign w_grant_b = b_valid & (~a_valid | ~r_last);
  assign w_addr    = w_grant_b ? b_addr : a_addr;
  assign w_data    = w_grant_b ? b_data : a_data;
  assign w_addr_ok = (w_addr == 2'b01) | (w_addr == 2'b10);

  // Only the ready line of the addressed target counts as an ack.
  assign w_ack = ((r_c_addr == 2'b01) & c_UART_ready) | ((r_c_addr == 2'b10) & c_VGA_ready);
  assign w_tmo = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_cnt      <= '0;
      r_c_valid  <= 1'b0;
      r_c_addr   <= 2'b00;
      r_c_data   <= 8'h00;
      r_ready    <= 2'b00;
      r_done     <= 2'b00;
      r_done_err <= 1'b0;
    end else begin
      r_ready    <= 2'b00;
      r_done     <= 2'b00;
      r_done_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_c_addr <= w_addr;
            r_c_data <= w_data;
            r_owner  <= w_grant_b;
            r_last   <= w_grant_b;
            r_ready  <= {w_grant_b, ~w_grant_b};
            r_cnt    <= '0;
            if (w_addr_ok) begin
              r_c_valid <= 1'b1;
              r_state   <= ST_DRIVE;
            end else begin
              // Rejected writes skip the bus entirely and report in the next cycle.
              r_done     <= {w_grant_b, ~w_grant_b};
              r_done_err <= 1'b1;
              r_state    <= ST_RESP;
            end
          end
        end
        ST_DRIVE: begin
          if (w_ack || w_tmo) begin
            r_c_valid  <= 1'b0;
            r_done     <= {r_owner, ~r_owner};
            r_done_err <= ~w_ack;
            r_state    <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign a_ready  = r_ready[0];
  assign b_ready  = r_ready[1];
  assign a_done   = r_done[0];
  assign b_done   = r_done[1];
  assign done_err = r_done_err;
  assign busy     = (r_state != ST_IDLE);
  assign c_valid  = r_c_valid;
  assign c_addr   = r_c_addr;
  assign c_data   = r_c_data;

endmodule

// File: tb/tb_config_arbiter.sv
// Randomized bench for config_arbiter against a transaction-level model
// (round-robin owner, address validity, ack-vs-timeout outcome).
module tb_config_arbiter;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic [1:0] a_addr = 2'b00, b_addr = 2'b00;
  logic [7:0] a_data = 8'h00, b_data = 8'h00;
  logic       a_ready, a_done, b_ready, b_done, done_err, busy, c_valid;
  logic [1:0] c_addr;
  logic [7:0] c_data;
  logic       c_UART_ready = 1'b0, c_VGA_ready = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  bit m_last = 1'b1;  // model: last granted requester, 1 = B

  config_arbiter #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready), .a_done(a_done),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready), .b_done(b_done),
    .done_err(done_err), .busy(busy), .c_valid(c_valid), .c_addr(c_addr), .c_data(c_data),
    .c_UART_ready(c_UART_ready), .c_VGA_ready(c_VGA_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_last = 1'b1;
  endtask

  // Single requester write; ack_k = c_valid cycle in which the target acks (1-based).
  task automatic run_one(input bit is_b, input logic [1:0] addr, input logic [7:0] data,
                         input int ack_k);
    bit ok;
    int exp_len, n;
    bit exp_err;
    ok      = (addr == 2'b01) || (addr == 2'b10);
    exp_len = !ok ? 0 : ((ack_k <= TMO) ? ack_k : TMO);
    exp_err = !ok || (ack_k > TMO);
    @(negedge clk);
    if (is_b) begin b_valid = 1'b1; b_addr = addr; b_data = data; end
    else      begin a_valid = 1'b1; a_addr = addr; a_data = data; end
    @(negedge clk);
    chk("own_ready",   32'(is_b ? b_ready : a_ready), 32'(1));
    chk("other_ready", 32'(is_b ? a_ready : b_ready), 32'(0));
    chk("c_addr",      32'(c_addr), 32'(addr));
    chk("c_data",      32'(c_data), 32'(data));
    chk("busy_grant",  32'(busy), 32'(1));
    a_valid = 1'b0; b_valid = 1'b0;
    n = 0;
    while (c_valid && n < 300) begin
      chk("done_early", 32'(a_done | b_done), 32'(0));
      n++;
      if (addr == 2'b01) begin
        c_UART_ready = (n == ack_k);
        c_VGA_ready  = 1'($urandom_range(0, 1));
      end else begin
        c_VGA_ready  = (n == ack_k);
        c_UART_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    c_UART_ready = 1'b0; c_VGA_ready = 1'b0;
    chk("cvalid_len",  32'(n), 32'(exp_len));
    chk("own_done",    32'(is_b ? b_done : a_done), 32'(1));
    chk("other_done",  32'(is_b ? a_done : b_done), 32'(0));
    chk("done_err",    32'(done_err), 32'(exp_err));
    chk("addr_stable", 32'({c_addr, c_data}), 32'({addr, data}));
    @(negedge clk);
    chk("done_clear",  32'(a_done | b_done | done_err), 32'(0));
    chk("busy_idle",   32'(busy), 32'(0));
    m_last = is_b;
  endtask

  // Both requesters held valid; targets ack immediately; grants must alternate.
  task automatic contend(input int grants);
    int g, wait_n;
    bit got_b;
    a_valid = 1'b1; a_addr = 2'b01; a_data = 8'($urandom);
    b_valid = 1'b1; b_addr = 2'b10; b_data = 8'($urandom);
    c_UART_ready = 1'b1; c_VGA_ready = 1'b1;
    for (g = 0; g < grants; g++) begin
      wait_n = 0;
      do begin @(negedge clk); wait_n++; end
      while (!(a_ready || b_ready) && wait_n < 20);
      chk("rr_timeout", 32'(a_ready | b_ready), 32'(1));
      chk("rr_single",  32'(a_ready & b_ready), 32'(0));
      got_b = b_ready;
      chk("rr_grant",   32'(got_b), 32'(!m_last));
      chk("rr_data",    32'(c_data), 32'(got_b ? b_data : a_data));
      m_last = got_b;
      if (got_b) b_data = 8'($urandom); else a_data = 8'($urandom);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    wait_n = 0;
    while (busy && wait_n < 20) begin @(negedge clk); wait_n++; end
    chk("rr_drain", 32'(busy), 32'(0));
    c_UART_ready = 1'b0; c_VGA_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int k;
    #1;
    chk("rst_outs", 32'({a_ready, a_done, b_ready, b_done, done_err, busy, c_valid}), 32'(0));
    chk("rst_bus",  32'({c_addr, c_data}), 32'(0));
    @(negedge clk);
    rst = 1'b1;

    // Directed: basic UART write, simultaneous arrival, invalid address, timeout, ack at timeout.
    run_one(1'b0, 2'b01, 8'h0C, 2);
    do_reset();
    contend(6);
    run_one(1'b1, 2'b00, 8'h33, 1);
    run_one(1'b0, 2'b10, 8'h44, 50);
    run_one(1'b0, 2'b10, 8'h55, TMO);
    run_one(1'b1, 2'b01, 8'h66, TMO + 1);
    run_one(1'b1, 2'b11, 8'h77, 1);

    // Reset in the middle of a VGA write, with A's next request already pending.
    @(negedge clk);
    a_valid = 1'b1; a_addr = 2'b10; a_data = 8'h99; c_UART_ready = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_cvalid", 32'(c_valid), 32'(1));
    end
    #2 rst = 1'b0;
    #1;
    chk("async_cvalid", 32'(c_valid), 32'(0));
    chk("async_busy",   32'(busy), 32'(0));
    c_UART_ready = 1'b0;
    a_valid = 1'b1; a_addr = 2'b01; a_data = 8'h5A;
    repeat (2) begin
      @(negedge clk);
      chk("rst_nodone", 32'(a_done | b_done | done_err), 32'(0));
    end
    rst = 1'b1;
    m_last = 1'b1;
    @(negedge clk);
    chk("post_ready", 32'(a_ready), 32'(1));
    chk("post_bus",   32'({c_valid, c_addr, c_data}), 32'({1'b1, 2'b01, 8'h5A}));
    a_valid = 1'b0; c_UART_ready = 1'b1;
    @(negedge clk);
    c_UART_ready = 1'b0;
    chk("post_done",  32'({a_done, done_err}), 32'({1'b1, 1'b0}));
    m_last = 1'b0;
    @(negedge clk);

    // Random mix of single writes and contention bursts.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        contend(int'($urandom_range(2, 5)));
      end else begin
        k = int'($urandom_range(1, TMO + 3));
        run_one(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), k);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
